decoder_2x4_mux_2x1: RTL and testbench
======================================

# decoder_2x4_mux_2x1

- Registered 2:1 multiplexer and enable-gated 2-to-4 one-hot decoder sharing two 1-bit data inputs.
- Small glue block in the dataflow-modeling library, used wherever a select-steered bit and a one-hot decode of the same two bits are needed together.
- Both results are computed combinationally and captured in output registers: one cycle of latency.

## Interface
Parameters:
- none; widths are fixed (2 data bits, 4 decoder outputs).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_a  input  1  data bit A; MSB of decoder index; mux input 0
- in_b  input  1  data bit B; LSB of decoder index; mux input 1
- sel  input  1  mux select: 0 selects in_a, 1 selects in_b
- en  input  1  decoder enable, active-high
- out_m  output  1  registered mux result
- out_d  output  4  registered one-hot decoder result

## Operation
- Mux next-state: mux_n = sel ? in_b : in_a.
- Decoder index: idx = {in_a, in_b} (in_a is bit 1).
- Decoder next-state:
  - en=1: out_d_n = 4'b0001 << idx, i.e. exactly one bit set.
  - en=0: out_d_n = 4'b0000.
- Mapping with en=1:
  - a=0,b=0 -> 0001
  - a=0,b=1 -> 0010
  - a=1,b=0 -> 0100
  - a=1,b=1 -> 1000
- Mux and decoder are independent: sel does not affect out_d, and en does not affect out_m.
- X/Z on any input propagates as X to the affected output; no special handling.
- No other state; the block has no FSM.

## Timing
- Reset (rst_n=0): out_m=0 and out_d=4'b0000 immediately, without waiting for a clock edge. Held while rst_n=0.
- Reset release: synchronous to nothing special. The first rising clk edge with rst_n=1 loads the computed values.
- Latency: inputs sampled at rising edge N appear on outputs after edge N, stable until edge N+1.
- Outputs change only on clk rising edge or rst_n assertion.
- Reset asserted mid-operation: outputs clear at once. Inputs present during reset are discarded.
- Simultaneous change of sel and data at one edge: the registered value uses the values sampled at that edge.
- en deasserted: out_d = 0000 one cycle later, regardless of a/b.

## Structure
- Shared package dfm_pkg holds:
  - localparam DEC_OUT_W = 4
  - localparam DEC_SEL_W = 2
  - typedef logic [DEC_OUT_W-1:0] onehot4_t
- One sub-module: decoder_2x4_core, purely combinational (a, b, en -> onehot4_t), instantiated once.
- Mux is a single continuous assignment in the top.
- One always_ff block with async reset holds out_m and out_d.

## Test plan
- Reset: hold rst_n=0 with a=1, b=1, sel=1, en=1 and toggle clk -> out_m=0, out_d=0000. Deassert rst_n; after the next edge -> out_m=1, out_d=1000.
- Mux sweep: en=0; drive all 8 {a,b,sel} combinations one per cycle -> out_m follows sel?b:a one cycle later (e.g. a=1,b=0,sel=0 -> 1; sel=1 -> 0). out_d stays 0000 throughout.
- Decoder sweep: en=1; drive {a,b} = 00, 01, 10, 11 -> out_d = 0001, 0010, 0100, 1000, each one cycle later, exactly one bit set.
- Enable gating: a=1, b=0, toggle en 1, 0, 1 -> out_d = 0100, 0000, 0100.
- Async reset mid-run: with out_d=0010, drop rst_n between clock edges -> out_d=0000 and out_m=0 before the next edge.
- Random: 10+ cycles of random a, b, sel, en checked against a reference model with 1-cycle delay -> zero mismatches.

Source files
------------

// File: rtl/decoder_2x4_mux_2x1_pkg.sv
// Shared definitions for the dataflow-modeling glue blocks: decoder widths
// and the one-hot result type.
package dfm_pkg;

    localparam int DEC_OUT_W = 4;
    localparam int DEC_SEL_W = 2;

    typedef logic [DEC_OUT_W-1:0] onehot4_t;

endpackage : dfm_pkg

// File: rtl/decoder_2x4_mux_2x1_if.sv
// Bundle of the data/control inputs and registered results of the
// decoder_2x4_mux_2x1 glue block. The master drives inputs and observes
// results; the slave (the block itself) does the opposite.
interface decoder_2x4_mux_2x1_if;
    import dfm_pkg::*;

    logic     in_a;
    logic     in_b;
    logic     sel;
    logic     en;
    logic     out_m;
    onehot4_t out_d;

    modport master (
        output in_a,
        output in_b,
        output sel,
        output en,
        input  out_m,
        input  out_d
    );

    modport slave (
        input  in_a,
        input  in_b,
        input  sel,
        input  en,
        output out_m,
        output out_d
    );

endinterface : decoder_2x4_mux_2x1_if

// File: rtl/decoder_2x4_mux_2x1_core.sv
// Purely combinational enable-gated 2-to-4 one-hot decoder.
// Index is {i_a, i_b} with i_a as the MSB. Unknown inputs give an unknown
// result, because the shift amount is X.
module decoder_2x4_core
    import dfm_pkg::*;
(
    input  logic     i_a,
    input  logic     i_b,
    input  logic     i_en,
    output onehot4_t o_dec
);

    logic [DEC_SEL_W-1:0] w_idx;
    onehot4_t             w_one;

    assign w_idx = {i_a, i_b};
    assign w_one = {{(DEC_OUT_W-1){1'b0}}, 1'b1};

    // Select one output bit from the index when enabled, all zeros otherwise.
    always_comb begin
        o_dec = {DEC_OUT_W{1'b0}};
        if (i_en == 1'b1) begin
            o_dec = w_one << w_idx;
        end else if (i_en == 1'b0) begin
            o_dec = {DEC_OUT_W{1'b0}};
        end else begin
            o_dec = {DEC_OUT_W{1'bx}};
        end
    end

endmodule : decoder_2x4_core

// File: rtl/decoder_2x4_mux_2x1.sv
// Registered 2:1 mux and enable-gated 2-to-4 one-hot decoder sharing the
// same two data bits. Both results are captured in output registers, giving
// one cycle of latency; an active-low reset clears them asynchronously.
module decoder_2x4_mux_2x1
    import dfm_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_2x4_mux_2x1_if.slave     bus
);

    logic     w_mux_n;
    onehot4_t w_dec_n;
    logic     r_out_m;
    onehot4_t r_out_d;

    // Mux input 0 is A, input 1 is B.
    assign w_mux_n = bus.sel ? bus.in_b : bus.in_a;

    decoder_2x4_core u_dec (
        .i_a   (bus.in_a),
        .i_b   (bus.in_b),
        .i_en  (bus.en),
        .o_dec (w_dec_n)
    );

    // Output registers: cleared at once by reset, otherwise load the
    // combinational results each rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_m <= 1'b0;
            r_out_d <= {DEC_OUT_W{1'b0}};
        end else begin
            r_out_m <= w_mux_n;
            r_out_d <= w_dec_n;
        end
    end

    assign bus.out_m = r_out_m;
    assign bus.out_d = r_out_d;

endmodule : decoder_2x4_mux_2x1

// File: tb/tb_decoder_2x4_mux_2x1.sv
// Directed plus random test of decoder_2x4_mux_2x1 with a one-cycle
// scoreboard of expected {out_m, out_d}.
module tb_decoder_2x4_mux_2x1;

    logic clk;
    logic rst_n;
    int   test_cnt;
    int   fail_cnt;
    logic [4:0] sb_q[$];

    decoder_2x4_mux_2x1_if bus();

    decoder_2x4_mux_2x1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: mux bit in [4], decoder one-hot in [3:0].
    function automatic logic [4:0] model(input logic a, input logic b,
                                         input logic s, input logic e);
        logic       m;
        logic [3:0] d;
        m = s ? b : a;
        if (!e) d = 4'b0000;
        else begin
            case ({a, b})
                2'b00:   d = 4'b0001;
                2'b01:   d = 4'b0010;
                2'b10:   d = 4'b0100;
                2'b11:   d = 4'b1000;
                default: d = 4'bxxxx;
            endcase
        end
        return {m, d};
    endfunction

    task automatic check_out(input string tag);
        logic [4:0] exp_v;
        logic [4:0] obs_v;
        test_cnt++;
        obs_v = {bus.out_m, bus.out_d};
        if (sb_q.size() == 0) begin
            fail_cnt++;
            $error("FAIL %s: scoreboard empty, observed %b", tag, obs_v);
        end else begin
            exp_v = sb_q.pop_front();
            assert (obs_v === exp_v) else begin
                fail_cnt++;
                $error("FAIL %s: observed m=%b d=%b expected m=%b d=%b",
                       tag, obs_v[4], obs_v[3:0], exp_v[4], exp_v[3:0]);
            end
        end
    endtask

    task automatic check_clear(input string tag);
        logic [4:0] obs_v;
        test_cnt++;
        obs_v = {bus.out_m, bus.out_d};
        assert (obs_v === 5'b00000) else begin
            fail_cnt++;
            $error("FAIL %s: observed m=%b d=%b expected m=0 d=0000",
                   tag, obs_v[4], obs_v[3:0]);
        end
    endtask

    // Drive at the falling edge, let one rising edge capture, check at the next falling edge.
    task automatic step(input logic a, input logic b, input logic s,
                        input logic e, input string tag);
        bus.in_a = a;
        bus.in_b = b;
        bus.sel  = s;
        bus.en   = e;
        sb_q.push_back(model(a, b, s, e));
        @(posedge clk);
        @(negedge clk);
        check_out(tag);
    endtask

    initial begin
        logic [2:0] v3;
        logic [1:0] v2;
        test_cnt = 0;
        fail_cnt = 0;
        rst_n    = 1'b0;
        bus.in_a = 1'b1;
        bus.in_b = 1'b1;
        bus.sel  = 1'b1;
        bus.en   = 1'b1;

        // Reset held with all inputs high: outputs stay cleared across edges.
        @(negedge clk);
        check_clear("reset_hold_0");
        @(negedge clk);
        check_clear("reset_hold_1");

        // Release reset; first edge loads a=1,b=1,sel=1,en=1.
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b1, "reset_release");

        // Mux sweep with decoder disabled.
        for (int i = 0; i < 8; i++) begin
            v3 = i[2:0];
            step(v3[2], v3[1], v3[0], 1'b0, $sformatf("mux_sweep_%0d", i));
        end

        // Decoder sweep with enable high.
        for (int i = 0; i < 4; i++) begin
            v2 = i[1:0];
            step(v2[1], v2[0], 1'b0, 1'b1, $sformatf("dec_sweep_%0d", i));
        end

        // Enable gating with a=1, b=0.
        step(1'b1, 1'b0, 1'b0, 1'b1, "en_gate_on0");
        step(1'b1, 1'b0, 1'b0, 1'b0, "en_gate_off");
        step(1'b1, 1'b0, 1'b0, 1'b1, "en_gate_on1");

        // Async reset between edges while out_d=0010, out_m=1.
        step(1'b0, 1'b1, 1'b1, 1'b1, "pre_async_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_clear("async_rst_immediate");
        @(posedge clk);
        @(negedge clk);
        check_clear("async_rst_held");
        rst_n = 1'b1;

        // Random cycles against the model.
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $sformatf("random_%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule : tb_decoder_2x4_mux_2x1
